sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Asynchronous-SRAM-style target: registers the pin inputs, commits writes and drives read data.
// Latency: inputs are sampled once; data_oe rises READ_LAT cycles after the sampled read request.
// No backpressure; bus ownership is controlled purely by ce_n/oe_n/we_n from the initiator.
module sram_responder #(
    parameter int DW       = 8,
    parameter int AW       = 16,
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          ce_n,
    input  logic          oe_n,
    input  logic          we_n,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          data_oe,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count,
    output logic          proto_err
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WRITE      = 2'd1;
    localparam logic [1:0] READ_WAIT  = 2'd2;
    localparam logic [1:0] READ_DRIVE = 2'd3;
    localparam int         DEPTH      = 2 ** MEM_AW;
    localparam logic [2:0] LAT_LOAD   = 3'(READ_LAT - 1);

    logic [AW-1:0] s_addr_q, addr_prev_q;
    logic          s_ce_n_q, s_oe_n_q, s_we_n_q;
    logic [DW-1:0] s_data_q;

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [DW-1:0] data_o_q, data_o_d;
    logic          data_oe_q, data_oe_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic [15:0]   rd_count_q, rd_count_d;
    logic          proto_err_q, proto_err_d;
    logic          commit;
    logic          s_wr, s_rd;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_addr_q    <= '0;
            s_ce_n_q    <= 1'b1;
            s_oe_n_q    <= 1'b1;
            s_we_n_q    <= 1'b1;
            s_data_q    <= '0;
            addr_prev_q <= '0;
        end else begin
            s_addr_q    <= addr;
            s_ce_n_q    <= ce_n;
            s_oe_n_q    <= oe_n;
            s_we_n_q    <= we_n;
            s_data_q    <= data_i;
            addr_prev_q <= s_addr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        proto_err_d = proto_err_q;
        commit      = 1'b0;
        s_wr        = !s_ce_n_q && !s_we_n_q;
        s_rd        = !s_ce_n_q && !s_oe_n_q;

        case (state_q)
            IDLE: begin
                if (s_wr) begin
                    state_d  = WRITE;
                    w_addr_d = s_addr_q;
                    w_data_d = s_data_q;
                end else if (s_rd) begin
                    state_d = READ_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            WRITE: begin
                if (s_wr) begin
                    if (s_addr_q != w_addr_q) proto_err_d = 1'b1;
                    w_addr_d = s_addr_q;
                    w_data_d = s_data_q;
                end else begin
                    commit     = 1'b1;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                // Both read states: deselect beats a write, which beats oe_n release.
                if (s_ce_n_q) begin
                    state_d = IDLE;
                end else if (!s_we_n_q) begin
                    state_d     = WRITE;
                    proto_err_d = 1'b1;
                    w_addr_d    = s_addr_q;
                    w_data_d    = s_data_q;
                end else if (s_oe_n_q) begin
                    state_d = IDLE;
                end else if (s_addr_q != addr_prev_q) begin
                    state_d = READ_WAIT;
                    cnt_d   = LAT_LOAD;
                end else if (state_q == READ_WAIT) begin
                    if (cnt_q <= 3'd1) state_d = READ_DRIVE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
        endcase

        if (state_q == READ_DRIVE && (state_d == IDLE || state_d == WRITE))
            rd_count_d = rd_count_q + 16'd1;

        // Storage read is registered here, so data_o lines up with data_oe.
        data_oe_d = (state_d == READ_DRIVE);
        data_o_d  = data_oe_d ? mem[s_addr_q[MEM_AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[w_addr_q[MEM_AW-1:0]] <= w_data_q;
    end

    assign data_o    = data_o_q;
    assign data_oe   = data_oe_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;
    assign proto_err = proto_err_q;
endmodule
